// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and helpers for the iterative ALU and its
// multiply/divide datapath.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_NOT   = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_RSVD  = 4'b1011;
  localparam logic [3:0] ALU_MUL   = 4'b1100;
  localparam logic [3:0] ALU_MULHU = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Multiply/divide opcodes all live in the 11xx corner of the map.
  function automatic logic is_iterative(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_muldiv_unit.sv
// Iterative shift-add multiplier and restoring unsigned divider sharing one
// 2*WIDTH accumulator; runs WIDTH iterations and then pulses done.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  // acc holds {high, low}: {product high, multiplier} or {remainder, quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand;
  logic [CW-1:0]      count;
  logic               running;
  logic               is_div;
  logic               take_high;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, operand};

  // A clear top bit on the trial subtraction means the divisor fit.
  always_comb begin
    acc_next = acc;
    if (is_div) begin
      if (!div_trial[WIDTH]) begin
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running   <= 1'b0;
      count     <= '0;
      acc       <= '0;
      operand   <= '0;
      is_div    <= 1'b0;
      take_high <= 1'b0;
    end else if (start) begin
      running   <= 1'b1;
      count     <= '0;
      acc       <= {{WIDTH{1'b0}}, a};
      operand   <= b;
      is_div    <= (op == ALU_DIVU) || (op == ALU_REMU);
      take_high <= (op == ALU_MULHU) || (op == ALU_REMU);
    end else if (running) begin
      if (done) begin
        running <= 1'b0;
        count   <= '0;
      end else begin
        acc   <= acc_next;
        count <= count + 1'b1;
      end
    end
  end

  assign done   = running && (count == LAST);
  assign result = take_high ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];

endmodule

// File: rtl/iterative_alu.sv
// Handshaked ALU: single-cycle ops resolve at acceptance, multiply/divide
// run through alu_muldiv_unit; results are held until the consumer accepts.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Busy
);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] simple_result;
  logic [SHW-1:0]   shamt;

  assign accept   = InValid && InReady;
  assign md_start = accept && is_iterative(ALUControl);
  assign shamt    = B[SHW-1:0];

  alu_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (ALUControl),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    simple_result = '0;
    case (ALUControl)
      ALU_ADD:  simple_result = A + B;
      ALU_SUB:  simple_result = A - B;
      ALU_AND:  simple_result = A & B;
      ALU_OR:   simple_result = A | B;
      ALU_NOT:  simple_result = ~A;
      ALU_XOR:  simple_result = A ^ B;
      ALU_SLL:  simple_result = A << shamt;
      ALU_SRL:  simple_result = A >> shamt;
      ALU_SLT:  simple_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: simple_result = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_SRA:  simple_result = $signed(A) >>> shamt;
      default:  simple_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = is_iterative(ALUControl) ? S_EXEC : S_DONE;
      S_EXEC:  if (md_done) state_next = S_DONE;
      S_DONE:  if (OutReady) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Result registers only load on a new result, so they hold through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUOut <= '0;
      Zero   <= 1'b0;
    end else if (accept && !is_iterative(ALUControl)) begin
      ALUOut <= simple_result;
      Zero   <= (simple_result == '0);
    end else if ((state == S_EXEC) && md_done) begin
      ALUOut <= md_result;
      Zero   <= (md_result == '0);
    end
  end

  assign InReady  = (state == S_IDLE);
  assign OutValid = (state == S_DONE);
  assign Busy     = (state != S_IDLE);

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu at WIDTH=32 and WIDTH=8, using a
// plain-arithmetic reference model and randomized operands.
module tb_iterative_alu;

  logic        clk;
  logic        reset;

  logic        in_valid, out_ready;
  logic [3:0]  ctl;
  logic [31:0] a, b;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] alu_out;

  logic        in_valid8, out_ready8;
  logic [3:0]  ctl8;
  logic [7:0]  a8, b8;
  logic        in_ready8, out_valid8, zero8, busy8;
  logic [7:0]  alu_out8;

  int tests = 0;
  int fails = 0;

  iterative_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .InValid(in_valid), .InReady(in_ready),
    .A(a), .B(b), .ALUControl(ctl), .OutValid(out_valid), .OutReady(out_ready),
    .ALUOut(alu_out), .Zero(zero), .Busy(busy)
  );

  iterative_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .InValid(in_valid8), .InReady(in_ready8),
    .A(a8), .B(b8), .ALUControl(ctl8), .OutValid(out_valid8), .OutReady(out_ready8),
    .ALUOut(alu_out8), .Zero(zero8), .Busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: the opcode semantics at width w, via 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input int w, input logic [3:0] op,
                                            input logic [31:0] da, input logic [31:0] db);
    longint unsigned mask, ua, ub, r;
    longint          sa, sb;
    int              sh;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, da} & mask;
    ub = {32'd0, db} & mask;
    sa = ua[w-1] ? $signed(ua | ~mask) : $signed(ua);
    sb = ub[w-1] ? $signed(ub | ~mask) : $signed(ub);
    sh = int'(ub % longint'(w));
    case (op)
      4'd0:    r = ua + ub;
      4'd1:    r = ua - ub;
      4'd2:    r = ua & ub;
      4'd3:    r = ua | ub;
      4'd4:    r = ~ua;
      4'd5:    r = ua ^ ub;
      4'd6:    r = ua << sh;
      4'd7:    r = ua >> sh;
      4'd8:    r = (sa < sb) ? 64'd1 : 64'd0;
      4'd9:    r = (ua < ub) ? 64'd1 : 64'd0;
      4'd10:   r = $unsigned(sa >>> sh);
      4'd12:   r = ua * ub;
      4'd13:   r = (ua * ub) >> w;
      4'd14:   r = (ub == 0) ? mask : ua / ub;
      4'd15:   r = (ub == 0) ? ua : ua % ub;
      default: r = 64'd0;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  task automatic drive(input bit w8, input logic v, input logic [3:0] op,
                       input logic [31:0] da, input logic [31:0] db);
    if (w8) begin
      in_valid8 = v; ctl8 = op; a8 = da[7:0]; b8 = db[7:0];
    end else begin
      in_valid = v; ctl = op; a = da; b = db;
    end
  endtask

  // Issues one request and waits (bounded) for OutValid; edges counts clock
  // edges after the acceptance edge before OutValid was seen high.
  task automatic run_op(input bit w8, input logic [3:0] op, input logic [31:0] da,
                        input logic [31:0] db, input bit scramble,
                        output logic [31:0] res, output logic z,
                        output int edges, output bit ready_seen);
    ready_seen = 1'b0;
    drive(w8, 1'b1, op, da, db);
    @(posedge clk); #1;
    drive(w8, 1'b0, op, da, db);
    edges = 0;
    while (((w8 ? out_valid8 : out_valid) !== 1'b1) && edges < 100) begin
      if ((w8 ? in_ready8 : in_ready) !== 1'b0) ready_seen = 1'b1;
      if (scramble) drive(w8, 1'($urandom), 4'($urandom), $urandom, $urandom);
      @(posedge clk); #1;
      edges++;
    end
    drive(w8, 1'b0, op, da, db);
    res = w8 ? {24'd0, alu_out8} : alu_out;
    z   = w8 ? zero8 : zero;
  endtask

  task automatic consume(input bit w8);
    if (w8) out_ready8 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready  = 1'b0;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset OutValid got %b want 0", out_valid); end
    tests++; if (alu_out !== 32'd0) begin fails++; $display("[TB] FAIL reset ALUOut got %h want 0", alu_out); end
    tests++; if (zero !== 1'b0) begin fails++; $display("[TB] FAIL reset Zero got %b want 0", zero); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset Busy got %b want 0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset InReady got %b want 1", in_ready); end
    tests++; if (in_ready8 !== 1'b1) begin fails++; $display("[TB] FAIL reset8 InReady got %b want 1", in_ready8); end
  endtask

  task automatic test_single_cycle();
    logic [3:0]  vop [13];
    logic [31:0] va  [13];
    logic [31:0] vb  [13];
    logic [31:0] vex [13];
    logic [31:0] res;
    logic [3:0]  op;
    logic [31:0] ra, rb, exp;
    logic        z;
    int          e;
    bit          rs;
    vop = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd8, 4'd9, 4'd10, 4'd7, 4'd6, 4'd11, 4'd5};
    va  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h80000000, 32'h80000000, 32'd1, 32'h1234, 32'h0000F0F0};
    vb  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1,
            32'd4, 32'd4, 32'd33, 32'd5, 32'h0000FF00};
    vex = '{32'd2, 32'd0, 32'd1, 32'd1, 32'hFFFFFFFE, 32'd0, 32'd1, 32'd0,
            32'hF8000000, 32'h08000000, 32'd2, 32'd0, 32'h00000FF0};
    for (int i = 0; i < 13; i++) begin
      run_op(1'b0, vop[i], va[i], vb[i], 1'b0, res, z, e, rs);
      tests++; if (res !== vex[i]) begin fails++; $display("[TB] FAIL single[%0d] op=%h ALUOut got %h want %h", i, vop[i], res, vex[i]); end
      tests++; if (z !== (vex[i] == 32'd0)) begin fails++; $display("[TB] FAIL single[%0d] Zero got %b want %b", i, z, vex[i] == 32'd0); end
      tests++; if (e !== 0) begin fails++; $display("[TB] FAIL single[%0d] latency got %0d edges want 0", i, e); end
      consume(1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 11));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      exp = ref_model(32, op, ra, rb);
      run_op(1'b0, op, ra, rb, 1'b0, res, z, e, rs);
      tests++; if (res !== exp || z !== (exp == 32'd0) || e !== 0) begin
        fails++; $display("[TB] FAIL rand_single op=%h a=%h b=%h ALUOut got %h want %h zero %b lat %0d", op, ra, rb, res, exp, z, e);
      end
      consume(1'b0);
    end
  endtask

  task automatic test_muldiv();
    logic [3:0]  vop [6];
    logic [31:0] va  [6];
    logic [31:0] vb  [6];
    logic [31:0] vex [6];
    logic [31:0] res, ra, rb, exp;
    logic [3:0]  op;
    logic        z;
    int          e;
    bit          rs;
    vop = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd14, 4'd15};
    va  = '{32'h00010000, 32'h00010000, 32'd100, 32'd100, 32'h1234, 32'h1234};
    vb  = '{32'h00010000, 32'h00010000, 32'd7, 32'd7, 32'd0, 32'd0};
    vex = '{32'd0, 32'd1, 32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234};
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, vop[i], va[i], vb[i], 1'b1, res, z, e, rs);
      tests++; if (res !== vex[i]) begin fails++; $display("[TB] FAIL muldiv[%0d] op=%h ALUOut got %h want %h", i, vop[i], res, vex[i]); end
      tests++; if (z !== (vex[i] == 32'd0)) begin fails++; $display("[TB] FAIL muldiv[%0d] Zero got %b want %b", i, z, vex[i] == 32'd0); end
      tests++; if (e !== 33) begin fails++; $display("[TB] FAIL muldiv[%0d] latency got %0d edges want 33", i, e); end
      tests++; if (rs !== 1'b0) begin fails++; $display("[TB] FAIL muldiv[%0d] InReady seen high during EXEC: got %b want 0", i, rs); end
      consume(1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(12, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      exp = ref_model(32, op, ra, rb);
      run_op(1'b0, op, ra, rb, 1'b1, res, z, e, rs);
      tests++; if (res !== exp || z !== (exp == 32'd0) || e !== 33) begin
        fails++; $display("[TB] FAIL rand_muldiv op=%h a=%h b=%h ALUOut got %h want %h zero %b lat %0d", op, ra, rb, res, exp, z, e);
      end
      consume(1'b0);
    end
  endtask

  task automatic test_width8();
    logic [31:0] res, ra, rb, exp;
    logic [3:0]  op;
    logic        z;
    int          e;
    bit          rs;
    run_op(1'b1, 4'd14, 32'd100, 32'd7, 1'b1, res, z, e, rs);
    tests++; if (res !== 32'd14) begin fails++; $display("[TB] FAIL w8 divu got %h want 0e", res); end
    tests++; if (e !== 9) begin fails++; $display("[TB] FAIL w8 divu latency got %0d edges want 9", e); end
    consume(1'b1);
    run_op(1'b1, 4'd15, 32'd100, 32'd7, 1'b1, res, z, e, rs);
    tests++; if (res !== 32'd2) begin fails++; $display("[TB] FAIL w8 remu got %h want 02", res); end
    tests++; if (e !== 9) begin fails++; $display("[TB] FAIL w8 remu latency got %0d edges want 9", e); end
    consume(1'b1);
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
      exp = ref_model(8, op, ra, rb);
      run_op(1'b1, op, ra, rb, 1'b0, res, z, e, rs);
      tests++; if (res !== exp || z !== (exp == 32'd0) || e !== (op[3:2] == 2'b11 ? 9 : 0)) begin
        fails++; $display("[TB] FAIL rand_w8 op=%h a=%h b=%h ALUOut got %h want %h zero %b lat %0d", op, ra, rb, res, exp, z, e);
      end
      consume(1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic        z;
    int          e;
    bit          rs;
    run_op(1'b0, 4'd0, 32'd5, 32'd9, 1'b0, res, z, e, rs);
    tests++; if (res !== 32'd14) begin fails++; $display("[TB] FAIL b2b first add got %h want 0000000e", res); end
    drive(1'b0, 1'b1, 4'd1, 32'd20, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1 || alu_out !== 32'd14 || zero !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("[TB] FAIL b2b hold[%0d] OutValid=%b ALUOut=%h Zero=%b InReady=%b want 1/0000000e/0/0", i, out_valid, alu_out, zero, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b release InReady=%b OutValid=%b want 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd1, 32'd20, 32'd3);
    tests++; if (out_valid !== 1'b1 || alu_out !== 32'd17) begin
      fails++; $display("[TB] FAIL b2b second OutValid=%b ALUOut=%h want 1/00000011", out_valid, alu_out);
    end
    consume(1'b0);
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    logic        z;
    int          e;
    bit          rs;
    bit          seen;
    drive(1'b0, 1'b1, 4'd12, 32'h00012345, 32'h00006789);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd12, 32'h00012345, 32'h00006789);
    repeat (10) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL midop Busy before reset got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0 || alu_out !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL midop after reset OutValid=%b ALUOut=%h Busy=%b InReady=%b want 0/0/0/1", out_valid, alu_out, busy, in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL midop aborted result appeared: got %b want 0", seen); end
    run_op(1'b0, 4'd0, 32'd3, 32'd4, 1'b0, res, z, e, rs);
    tests++; if (res !== 32'd7 || z !== 1'b0 || e !== 0) begin
      fails++; $display("[TB] FAIL midop add 3+4 got %h zero %b lat %0d want 00000007/0/0", res, z, e);
    end
    consume(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; ctl = 4'd0; a = 32'd0; b = 32'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; ctl8 = 4'd0; a8 = 8'd0; b8 = 8'd0;
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_width8();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised, handshaked successor to the single-cycle processor ALU.
- Keeps the existing add/sub/and/or/not/slt opcode encodings and adds xor, shifts, sltu, and iterative multiply/divide.
- Sits between decode/issue and writeback. Valid/ready handshakes on input and output let the pipeline stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4 and a power of 2.
- SHW, log2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- InValid  in  1  request valid
- InReady  out  1  block can accept a request
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- ALUControl  in  4  opcode
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts result
- ALUOut  out  WIDTH  result
- Zero  out  1  ALUOut == 0
- Busy  out  1  request in flight (state != IDLE)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high (reset). At any edge with reset=1:
  - state=IDLE, iteration counter=0
  - OutValid=0, ALUOut=0, Zero=0, Busy=0
  - InReady=1 in the following cycle
- Reset has priority over everything, including mid-iteration. An in-flight op is discarded with no output.
- Opcodes (ALUControl):
  - 0000 add A+B; 0001 sub A-B; 0010 and; 0011 or; 0100 not = ~A (B ignored)
  - 0101 xor; 0110 sll A<<B[SHW-1:0]; 0111 srl; 1000 slt signed (1/0); 1001 sltu; 1010 sra
  - 1100 mul = low WIDTH bits of A*B; 1101 mulhu = high WIDTH bits of unsigned A*B
  - 1110 divu; 1111 remu
  - 1011 is reserved: result 0, Zero=1, single-cycle.
- Arithmetic: add/sub wrap modulo 2^WIDTH, with no carry/overflow output.
- Divide by zero: divu → all ones; remu → A.
- Divider: restoring, unsigned. Multiplier: shift-add with a 2*WIDTH accumulator.
- State machine: IDLE, EXEC, DONE. InReady = (state==IDLE). Acceptance = edge with InValid && InReady; A, B and ALUControl are latched at acceptance.
  - IDLE → DONE at acceptance for single-cycle ops. Result is registered; OutValid is high in the cycle right after the acceptance edge (latency 1).
  - IDLE → EXEC at acceptance for 1100–1111. EXEC runs exactly WIDTH iterations, one per cycle, then → DONE. OutValid rises WIDTH+1 edges after the acceptance edge.
  - DONE: OutValid=1. ALUOut and Zero hold stable until the edge with OutReady=1, then → IDLE. There is no output-to-input bypass, so minimum request spacing is 2 cycles.
- Input side: outside IDLE, InValid, A, B and ALUControl are ignored; a changing A/B during EXEC must not affect the result.
- Output registers: Zero is registered with ALUOut (never combinational from inputs). ALUOut/Zero keep their last value when OutValid=0.

Decomposition:
- Package alu_pkg:
  - 4-bit opcode localparams (ALU_ADD … ALU_REMU, ALU_RSVD)
  - state encoding localparams (S_IDLE, S_EXEC, S_DONE)
  - helper function is_iterative(op)
- Sub-module alu_muldiv_unit (parameter WIDTH) holds the iterative datapath:
  - inputs: start, op, a, b
  - outputs: done pulse, result
  - owns the iteration counter and the 2*WIDTH accumulator/remainder registers
- Top iterative_alu holds the FSM, handshake, single-cycle combinational ops and output registers.

Test Plan:
- Single-cycle ops: WIDTH=32, A=1, B=1. add → ALUOut=2, Zero=0, OutValid 1 cycle after accept. sub → 0, Zero=1. and → 1. or → 1. not → 0xFFFFFFFE. slt → 0.
- Compares and shifts:
  - A=0xFFFFFFFF, B=1: slt → 1; sltu → 0.
  - A=0x80000000, B=4: sra → 0xF8000000; srl → 0x08000000.
  - sll with B=33 uses shift 1: A=1 → 2.
- Multiply: A=B=0x00010000. mul → 0, Zero=1; mulhu → 1. OutValid rises exactly 33 edges after acceptance; InReady=0 throughout; A/B toggled during EXEC have no effect.
- Divide:
  - 100/7: divu → 14, remu → 2.
  - B=0, A=0x1234: divu → 0xFFFFFFFF, remu → 0x1234.
  - Rerun 100/7 with WIDTH=8: divu → 14, remu → 2, OutValid after 9 edges.
- Backpressure: after an add result, hold OutReady=0 for 5 cycles while driving a second InValid.
  - ALUOut/Zero/OutValid stay stable and InReady stays 0; the second request is not accepted.
  - With OutReady=1: DONE → IDLE, the second request is accepted next cycle and its result is correct.
- Reset mid-op: assert reset for 1 cycle at EXEC iteration 10 of a mul.
  - Next cycle: OutValid=0, ALUOut=0, Busy=0, InReady=1, and the aborted result never appears.
  - A following add 3+4 returns 7.
